// File: rtl/lockstep_clk_sync.sv
// lockstep_clk_sync: keeps NUM_CORES copies of a core in instruction lockstep.
// Each participating copy runs until it retires one instruction and is then
// held. Once every participating copy has retired, a single global retire
// pulse is emitted and all copies are released together. A watchdog flags
// divergence if a held copy waits too long for the others.
//
// Ports:
//   clk_i         harness clock
//   rst_i         asynchronous active-high reset
//   enable_i      global run request; low parks all cores
//   core_mask_i   per-core participation mask (live)
//   retire_i      per-core retire pulse, honoured only while clk_en_o is high
//   clk_en_o      per-core clock enable for the external clock gate
//   waiting_o     per-core "retired and held" indication
//   retire_o      one-cycle pulse when all participating cores have retired
//   retire_cnt_o  saturating count of retire_o pulses
//   timeout_o     sticky divergence flag
module lockstep_clk_sync #(
  parameter int unsigned NUM_CORES = 2,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic [NUM_CORES-1:0] core_mask_i,
  input  logic [NUM_CORES-1:0] retire_i,
  output logic [NUM_CORES-1:0] clk_en_o,
  output logic [NUM_CORES-1:0] waiting_o,
  output logic                 retire_o,
  output logic [CNT_W-1:0]     retire_cnt_o,
  output logic                 timeout_o
);

  localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] TIMEOUT_V = WCNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_SYNC,
    ST_HALT
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_CORES-1:0] waiting_q, waiting_d;
  logic [WCNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                 retire_q, retire_d;
  logic [CNT_W-1:0]     retire_cnt_q, retire_cnt_d;
  logic                 timeout_q, timeout_d;

  logic [NUM_CORES-1:0] clk_en_c;
  logic [NUM_CORES-1:0] captured_c;
  logic [NUM_CORES-1:0] eff_c;
  logic                 sync_ok_c;
  logic                 any_wait_c;
  logic                 wait_inc_c;
  logic [WCNT_W-1:0]    wait_cnt_inc_c;
  logic                 tmo_hit_c;

  // Clock enables and sync detection, derived from registered state plus live mask.
  always_comb begin
    clk_en_c       = '0;
    if (state_q == ST_RUN) begin
      clk_en_c = core_mask_i & ~waiting_q;
    end
    captured_c     = retire_i & clk_en_c;
    eff_c          = waiting_q | captured_c;
    sync_ok_c      = (state_q == ST_RUN) && (|core_mask_i) &&
                     ((eff_c & core_mask_i) == core_mask_i);
    any_wait_c     = |(waiting_q & core_mask_i);
    wait_inc_c     = (state_q == ST_RUN) && any_wait_c && !sync_ok_c;
    // Saturate at TIMEOUT so a count accumulated across pauses cannot wrap.
    wait_cnt_inc_c = (wait_cnt_q == TIMEOUT_V) ? wait_cnt_q
                                               : wait_cnt_q + WCNT_W'(1);
    tmo_hit_c      = wait_inc_c && (wait_cnt_inc_c == TIMEOUT_V);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    waiting_d    = waiting_q;
    wait_cnt_d   = wait_cnt_q;
    retire_d     = 1'b0;
    retire_cnt_d = retire_cnt_q;
    timeout_d    = timeout_q;

    unique case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        waiting_d = waiting_q | captured_c;
        if (wait_inc_c) begin
          wait_cnt_d = wait_cnt_inc_c;
        end
        if (!enable_i) begin
          // Pause: held cores and the wait count survive until re-enable.
          state_d = ST_IDLE;
        end else if (sync_ok_c) begin
          state_d    = ST_SYNC;
          waiting_d  = '0;
          wait_cnt_d = '0;
          retire_d   = 1'b1;
          if (retire_cnt_q != CNT_MAX) begin
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
          end
        end else if (tmo_hit_c) begin
          state_d   = ST_HALT;
          timeout_d = 1'b1;
        end
      end

      ST_SYNC: begin
        waiting_d  = '0;
        wait_cnt_d = '0;
        state_d    = enable_i ? ST_RUN : ST_IDLE;
      end

      ST_HALT: begin
        timeout_d = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      waiting_q    <= '0;
      wait_cnt_q   <= '0;
      retire_q     <= 1'b0;
      retire_cnt_q <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      waiting_q    <= waiting_d;
      wait_cnt_q   <= wait_cnt_d;
      retire_q     <= retire_d;
      retire_cnt_q <= retire_cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  assign clk_en_o     = clk_en_c;
  assign waiting_o    = waiting_q & core_mask_i;
  assign retire_o     = retire_q;
  assign retire_cnt_o = retire_cnt_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_lockstep_clk_sync.sv
// Bench for lockstep_clk_sync: two instances (2 cores / TIMEOUT=8 / CNT_W=2 and
// 3 cores / TIMEOUT=64 / CNT_W=16), a per-instance reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_lockstep_clk_sync;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: 2 cores
  logic        a_en;
  logic [1:0]  a_mask, a_ret, a_clk_en, a_wait;
  logic        a_retire, a_tmo;
  logic [1:0]  a_cnt;

  // Instance B: 3 cores
  logic        b_en;
  logic [2:0]  b_mask, b_ret, b_clk_en, b_wait;
  logic        b_retire, b_tmo;
  logic [15:0] b_cnt;

  lockstep_clk_sync #(.NUM_CORES(2), .TIMEOUT(8), .CNT_W(2)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .enable_i(a_en), .core_mask_i(a_mask),
    .retire_i(a_ret), .clk_en_o(a_clk_en), .waiting_o(a_wait),
    .retire_o(a_retire), .retire_cnt_o(a_cnt), .timeout_o(a_tmo)
  );

  lockstep_clk_sync #(.NUM_CORES(3), .TIMEOUT(64), .CNT_W(16)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .enable_i(b_en), .core_mask_i(b_mask),
    .retire_i(b_ret), .clk_en_o(b_clk_en), .waiting_o(b_wait),
    .retire_o(b_retire), .retire_cnt_o(b_cnt), .timeout_o(b_tmo)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: phase 0 parked, 1 running, 2 release pulse, 3 halted.
  typedef struct {
    int       phase;
    bit [7:0] held;
    int       waited;
    int       cnt;
    bit       pulse;
    bit       tmo;
  } mdl_t;

  mdl_t ma, mb;

  task automatic mdl_step(inout mdl_t m, input int n, input int timeout,
                          input int cntmax, input bit en,
                          input bit [7:0] mask_in, input bit [7:0] ret_in);
    bit [7:0] nmask, mask, ret, go, fresh, eff;
    bit       all_done, anyw;
    nmask = 8'((1 << n) - 1);
    mask  = mask_in & nmask;
    ret   = ret_in & nmask;
    m.pulse = 1'b0;
    case (m.phase)
      0: if (en) m.phase = 1;
      1: begin
        go       = mask & ~m.held;
        fresh    = ret & go;
        eff      = m.held | fresh;
        all_done = (mask != 0) && ((eff & mask) == mask);
        anyw     = (m.held & mask) != 0;
        if (anyw && !all_done && m.waited < timeout) m.waited++;
        m.held = m.held | fresh;
        if (!en) m.phase = 0;
        else if (all_done) begin
          m.phase  = 2;
          m.held   = 0;
          m.waited = 0;
          m.pulse  = 1'b1;
          if (m.cnt < cntmax) m.cnt++;
        end else if (anyw && m.waited >= timeout) begin
          m.phase = 3;
          m.tmo   = 1'b1;
        end
      end
      2: m.phase = en ? 1 : 0;
      default: ;
    endcase
  endtask

  function automatic bit [7:0] mdl_clken(input mdl_t m, input bit [7:0] mask);
    return (m.phase == 1) ? (mask & ~m.held) : 8'h00;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma = '{default: 0};
      mb = '{default: 0};
    end else begin
      mdl_step(ma, 2, 8, 3, a_en, 8'(a_mask), 8'(a_ret));
      mdl_step(mb, 3, 64, 65535, b_en, 8'(b_mask), 8'(b_ret));
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Per-cycle model comparison, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      chk("A.clk_en",  int'(a_clk_en), int'(mdl_clken(ma, 8'(a_mask))));
      chk("A.waiting", int'(a_wait),   int'(ma.held & 8'(a_mask)));
      chk("A.retire",  int'(a_retire), int'(ma.pulse));
      chk("A.cnt",     int'(a_cnt),    ma.cnt);
      chk("A.timeout", int'(a_tmo),    int'(ma.tmo));
      chk("B.clk_en",  int'(b_clk_en), int'(mdl_clken(mb, 8'(b_mask))));
      chk("B.waiting", int'(b_wait),   int'(mb.held & 8'(b_mask)));
      chk("B.retire",  int'(b_retire), int'(mb.pulse));
      chk("B.cnt",     int'(b_cnt),    mb.cnt);
      chk("B.timeout", int'(b_tmo),    int'(mb.tmo));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int cnt_exp [5] = '{1, 2, 3, 3, 3};

  initial begin
    rst = 1'b1;
    a_en = 1'b0; a_mask = 2'b00; a_ret = 2'b00;
    b_en = 1'b0; b_mask = 3'b000; b_ret = 3'b000;
    repeat (2) tick();
    chk("rst_clk_en",  int'(a_clk_en), 0);
    chk("rst_waiting", int'(a_wait),   0);
    chk("rst_retire",  int'(a_retire), 0);
    chk("rst_cnt",     int'(a_cnt),    0);
    chk("rst_timeout", int'(a_tmo),    0);
    rst = 1'b0;
    tick();

    // Core0 retires first, core1 four cycles later.
    a_en = 1'b1; a_mask = 2'b11;
    tick();
    chk("t1_run_clk_en", int'(a_clk_en), 3);
    a_ret = 2'b01;
    tick();
    a_ret = 2'b00;
    chk("t1_wait",   int'(a_wait),   1);
    chk("t1_clk_en", int'(a_clk_en), 2);
    repeat (3) begin
      tick();
      chk("t1_hold_wait",   int'(a_wait),   1);
      chk("t1_hold_clk_en", int'(a_clk_en), 2);
    end
    a_ret = 2'b10;
    tick();
    a_ret = 2'b00;
    chk("t1_retire",      int'(a_retire), 1);
    chk("t1_cnt",         int'(a_cnt),    1);
    chk("t1_sync_wait",   int'(a_wait),   0);
    chk("t1_sync_clk_en", int'(a_clk_en), 0);
    tick();
    chk("t1_after_retire", int'(a_retire), 0);
    chk("t1_after_clk_en", int'(a_clk_en), 3);

    // Dropping the lagging core from the mask releases the waiting one.
    a_ret = 2'b01;
    tick();
    a_ret = 2'b00;
    tick();
    a_mask = 2'b01;
    #1;
    chk("t4_masked_clk_en", int'(a_clk_en), 0);
    tick();
    chk("t4_retire", int'(a_retire), 1);
    chk("t4_cnt",    int'(a_cnt),    2);
    tick();
    chk("t4_wait",   int'(a_wait),   0);
    chk("t4_clk_en", int'(a_clk_en), 1);
    a_mask = 2'b11;

    // Pause while core0 is held; no timeout, held state survives.
    a_ret = 2'b01;
    tick();
    a_ret = 2'b00;
    a_en  = 1'b0;
    tick();
    repeat (20) tick();
    chk("t5_timeout", int'(a_tmo),    0);
    chk("t5_wait",    int'(a_wait),   1);
    chk("t5_clk_en",  int'(a_clk_en), 0);
    a_en = 1'b1;
    tick();
    chk("t5_resume_clk_en", int'(a_clk_en), 2);
    a_ret = 2'b10;
    tick();
    a_ret = 2'b00;
    chk("t5_retire", int'(a_retire), 1);
    chk("t5_cnt",    int'(a_cnt),    3);
    tick();

    // Core1 never retires: halt after 8 wait cycles.
    a_ret = 2'b01;
    tick();
    a_ret = 2'b00;
    repeat (7) tick();
    chk("t3_before_timeout", int'(a_tmo), 0);
    tick();
    chk("t3_timeout", int'(a_tmo),    1);
    chk("t3_clk_en",  int'(a_clk_en), 0);
    a_ret = 2'b11;
    repeat (5) tick();
    chk("t3_sticky",        int'(a_tmo),    1);
    chk("t3_halt_clk_en",   int'(a_clk_en), 0);
    chk("t3_halt_retire",   int'(a_retire), 0);
    chk("t3_halt_cnt",      int'(a_cnt),    3);
    chk("t3_halt_waiting",  int'(a_wait),   1);
    a_ret = 2'b00;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t3_rst_timeout", int'(a_tmo), 0);
    tick();

    // Saturating counter with CNT_W=2.
    for (int k = 0; k < 5; k++) begin
      a_ret = 2'b11;
      tick();
      a_ret = 2'b00;
      chk("t6_retire", int'(a_retire), 1);
      chk("t6_cnt",    int'(a_cnt),    cnt_exp[k]);
      tick();
    end
    a_ret = 2'b01;
    tick();
    a_ret = 2'b00;
    chk("t6_wait_pre_rst", int'(a_wait), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_clk_en",  int'(a_clk_en), 0);
    chk("t6_async_waiting", int'(a_wait),   0);
    chk("t6_async_retire",  int'(a_retire), 0);
    chk("t6_async_cnt",     int'(a_cnt),    0);
    chk("t6_async_timeout", int'(a_tmo),    0);
    tick();
    rst = 1'b0;
    tick();

    // Three cores retiring together sync one cycle later with no hold.
    b_en = 1'b1; b_mask = 3'b111;
    tick();
    chk("t2_clk_en", int'(b_clk_en), 7);
    b_ret = 3'b111;
    tick();
    b_ret = 3'b000;
    chk("t2_retire", int'(b_retire), 1);
    chk("t2_wait",   int'(b_wait),   0);
    chk("t2_cnt",    int'(b_cnt),    1);
    tick();
    chk("t2_after_clk_en", int'(b_clk_en), 7);
    chk("t2_after_retire", int'(b_retire), 0);
    chk("t2_after_wait",   int'(b_wait),   0);

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
